// File: rtl/chc2442_spi_ctrl_if.sv
// CHC2442 SPI controller bundle: FIFO read side, SPI pins, readback and status.
// master modport is the controller's view; slave modport is the environment's view
// (FIFO plus SPI peripheral).
interface chc2442_spi_ctrl_if;
  logic        ctrl_en;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [25:0] fifo_dout;
  logic        spi_csn;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [23:0] rd_data_o;
  logic        rd_data_vld;
  logic        drop_o;
  logic        busy_o;

  modport master (
    input  ctrl_en, fifo_empty, fifo_dout, spi_miso,
    output fifo_rd_en, spi_csn, spi_sclk, spi_mosi,
           rd_data_o, rd_data_vld, drop_o, busy_o
  );

  modport slave (
    output ctrl_en, fifo_empty, fifo_dout, spi_miso,
    input  fifo_rd_en, spi_csn, spi_sclk, spi_mosi,
           rd_data_o, rd_data_vld, drop_o, busy_o
  );
endinterface

// File: rtl/chc2442_spi_ctrl.sv
// Purpose: drains the CHC2442 config FIFO and sends each valid word as a 24-bit SPI frame.
// Latency: 3 cycles from non-empty FIFO to CSN low; frame costs 3+CS_SETUP+48*CLK_DIV+CS_HOLD+GAP.
// Backpressure: pops only when idle with ctrl_en=1; started frames always complete. Readback: CHC2442_READBACK_EN.
module chc2442_spi_ctrl #(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int GAP      = 4
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_rst,
  chc2442_spi_ctrl_if.master       io_bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_POP, S_LOAD, S_CSS, S_SHIFT, S_CSH, S_GAP
  } state_t;

  // Terminal counts for the shared 16-bit cycle counter.
  localparam logic [15:0] LP_DIV_END = 16'(CLK_DIV - 1);
  localparam logic [15:0] LP_CSS_END = 16'(CS_SETUP - 1);
  localparam logic [15:0] LP_CSH_END = 16'(CS_HOLD - 1);
  localparam logic [15:0] LP_GAP_END = 16'(GAP - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [5:0]  r_edge;      // SCLK edges issued in the current frame (48 per frame)
  logic [23:0] r_sreg;      // outgoing payload; bit 23 is always the next bit on MOSI's heels
  logic        r_fifo_rd_en;
  logic        r_csn;
  logic        r_sclk;
  logic        r_mosi;
  logic        r_drop;
  logic        r_busy;
`ifdef CHC2442_READBACK_EN
  logic        r_is_rd;
  logic [23:0] r_rx;
  logic [23:0] r_rd_data;
  logic        r_rd_vld;
`endif

  // Frame sequencer: every output is a register updated here.
  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_edge       <= '0;
      r_sreg       <= '0;
      r_fifo_rd_en <= 1'b0;
      r_csn        <= 1'b1;
      r_sclk       <= 1'b0;
      r_mosi       <= 1'b0;
      r_drop       <= 1'b0;
      r_busy       <= 1'b0;
`ifdef CHC2442_READBACK_EN
      r_is_rd      <= 1'b0;
      r_rx         <= '0;
      r_rd_data    <= '0;
      r_rd_vld     <= 1'b0;
`endif
    end else begin
      r_fifo_rd_en <= 1'b0;
      r_drop       <= 1'b0;
`ifdef CHC2442_READBACK_EN
      r_rd_vld     <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (io_bus.ctrl_en && !io_bus.fifo_empty) begin
            r_fifo_rd_en <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_POP;
          end
        end
        S_POP: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          if (!io_bus.fifo_dout[25]) begin
            // Invalid command: discard without touching the bus.
            r_drop  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_sreg  <= io_bus.fifo_dout[23:0];
            r_mosi  <= io_bus.fifo_dout[23];
            r_csn   <= 1'b0;
            r_cnt   <= '0;
`ifdef CHC2442_READBACK_EN
            r_is_rd <= io_bus.fifo_dout[24];
`endif
            r_state <= S_CSS;
          end
        end
        S_CSS: begin
          if (r_cnt == LP_CSS_END) begin
            r_cnt   <= '0;
            r_edge  <= '0;
            r_state <= S_SHIFT;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_SHIFT: begin
          if (r_cnt == LP_DIV_END) begin
            r_cnt  <= '0;
            r_sclk <= ~r_sclk;
            r_edge <= r_edge + 6'd1;
`ifdef CHC2442_READBACK_EN
            // MISO is taken on the same clock that drives SCLK high.
            if (!r_sclk) r_rx <= {r_rx[22:0], io_bus.spi_miso};
`endif
            if (r_sclk) begin
              // Falling edge: advance MOSI to the next payload bit.
              r_sreg <= {r_sreg[22:0], 1'b0};
              r_mosi <= r_sreg[22];
              if (r_edge == 6'd47) r_state <= S_CSH;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_CSH: begin
          if (r_cnt == LP_CSH_END) begin
            r_cnt   <= '0;
            r_csn   <= 1'b1;
`ifdef CHC2442_READBACK_EN
            if (r_is_rd) begin
              r_rd_data <= r_rx;
              r_rd_vld  <= 1'b1;
            end
`endif
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == LP_GAP_END) begin
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign io_bus.fifo_rd_en  = r_fifo_rd_en;
  assign io_bus.spi_csn     = r_csn;
  assign io_bus.spi_sclk    = r_sclk;
  assign io_bus.spi_mosi    = r_mosi;
  assign io_bus.drop_o      = r_drop;
  assign io_bus.busy_o      = r_busy;
`ifdef CHC2442_READBACK_EN
  assign io_bus.rd_data_o   = r_rd_data;
  assign io_bus.rd_data_vld = r_rd_vld;
`else
  assign io_bus.rd_data_o   = '0;
  assign io_bus.rd_data_vld = 1'b0;
`endif

endmodule

// File: doc/chc2442_spi_ctrl.md
# chc2442_spi_ctrl

SPI master that drains the CHC2442 configuration FIFO and serialises each queued 26-bit command word onto the CHC2442 3-wire-plus-MISO SPI bus. Sits on the read side of the configuration write buffer, in the read clock domain. It pops one word at a time, issues a 24-bit frame with programmable chip-select setup, hold and inter-frame gap, and optionally captures readback data for read commands.

## Interface
Parameters:
- CLK_DIV, 4 — SCLK half-period in sys_clk cycles (≥1)
- CS_SETUP, 2 — cycles CSN low before first SCLK rising edge (≥1)
- CS_HOLD, 2 — cycles after last SCLK falling edge before CSN rises (≥1)
- GAP, 4 — minimum CSN-high cycles between frames (≥1)

Ports:
- sys_clk  in  1  block clock (same as the FIFO read clock)
- sys_rst  in  1  synchronous, active-high reset
- ctrl_en  in  1  1 = allowed to start new frames; a frame in progress always completes
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_en  out  1  FIFO pop strobe, one-cycle pulse
- fifo_dout  in  26  FIFO word, valid one cycle after fifo_rd_en; [25] command valid, [24] 0 write / 1 read, [23:0] frame payload
- spi_csn  out  1  chip select, active low
- spi_sclk  out  1  SPI clock, CPOL=0
- spi_mosi  out  1  serial data out, MSB first
- spi_miso  in  1  serial data in
- rd_data_o  out  24  readback data from the most recent read frame
- rd_data_vld  out  1  one-cycle pulse, rd_data_o updated
- drop_o  out  1  one-cycle pulse, popped word had [25]=0 and was discarded
- busy_o  out  1  high in every state except IDLE

## Operation
- FSM states: IDLE, POP, LOAD, CSS, SHIFT, CSH, GAP.
- IDLE: if ctrl_en=1 and fifo_empty=0 → POP.
- POP: fifo_rd_en=1 for exactly this cycle → LOAD.
- LOAD: sample fifo_dout into shift register and type flag. If [25]=0: drop_o=1 → IDLE (no frame). Otherwise → CSS with spi_csn=0 and spi_mosi=payload[23].
- CSS: hold for CS_SETUP cycles → SHIFT.
- SHIFT: SCLK starts low and toggles every CLK_DIV cycles, giving 24 full periods. MOSI changes on each falling edge and is stable on rising edges. MISO is sampled on the sys_clk cycle where SCLK goes 0→1, shifted in MSB first. The state ends on the 24th falling edge with SCLK low → CSH.
- CSH: hold CS_HOLD cycles, then spi_csn=1. For read frames, rd_data_o is loaded and rd_data_vld pulses on the same cycle → GAP.
- GAP: CSN high for GAP cycles → IDLE.
- Write frames never modify rd_data_o.
- Back-to-back words: the next POP occurs on the cycle after GAP ends (via IDLE), so the inter-frame CSN-high time is GAP+3 cycles.
- ctrl_en deasserted mid-frame: the frame completes, and no new POP follows.
- fifo_empty rising while in LOAD or later: no effect, because the word is already captured.

## Timing
- Reset values: spi_csn=1, spi_sclk=0, spi_mosi=0, fifo_rd_en=0, rd_data_o=0, rd_data_vld=0, drop_o=0, busy_o=0, FSM=IDLE.
- All outputs are registered.
- Latency from fifo_empty=0 (with ctrl_en=1) in IDLE to spi_csn falling: 3 cycles (IDLE→POP→LOAD→CSS).
- Frame duration with spi_csn low: CS_SETUP + 48·CLK_DIV + CS_HOLD cycles.
- Total frame cost in cycles: 3 + CS_SETUP + 48·CLK_DIV + CS_HOLD + GAP.
- sys_rst mid-frame: all outputs reach their reset values on the next edge and the word in flight is lost. No extra FIFO pop occurs.
- Counters are 16 bits and saturate-free. Parameters must stay below 2^15.

## Configuration
- CHC2442_READBACK_EN defined:
  - MISO is captured during read frames ([24]=1).
  - rd_data_o and rd_data_vld behave as specified above.
- CHC2442_READBACK_EN undefined:
  - spi_miso is ignored.
  - rd_data_o is tied to 0 and rd_data_vld to 0.
  - Read frames are shifted exactly like write frames.

## Test plan
- CLK_DIV=2, CS_SETUP=2, CS_HOLD=2, GAP=4. Push write word 26'h2_A5_5A_3C → one frame with MOSI = 0xA55A3C MSB first, 24 SCLK rising edges, spi_csn low for 100 cycles, no rd_data_vld.
- Same parameters, macro defined. Push read word 26'h3_80_00_01 with MISO model returning 0xC0FFEE → rd_data_o=24'hC0FFEE, rd_data_vld pulses once when spi_csn rises. Rebuild without the macro → rd_data_vld never asserts.
- Push 3 words back-to-back → exactly 3 fifo_rd_en pulses, 3 frames, spi_csn high ≥ 7 cycles between frames, payloads in order.
- Push 26'h0_12_34_56 → drop_o pulses once, spi_csn stays 1, block returns to IDLE 3 cycles after the pop.
- Assert sys_rst during the 10th SCLK period → next edge: spi_csn=1, spi_sclk=0, busy_o=0. The next FIFO word is then sent intact.
- ctrl_en=0 with FIFO non-empty → no fifo_rd_en. Drop ctrl_en mid-frame → the frame finishes and no further pop follows.
